// File: rtl/cpu_pkg.sv
// Shared CPU constants and the MEM/WB pipeline payload type.
package cpu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned RIDX_W = 5;

    // Hard-wired zero register; writes to it are dropped.
    localparam int unsigned XZR_IDX = 31;

    // Load transfer sizes in bytes.
    localparam logic [3:0] XFER_B = 4'd1;
    localparam logic [3:0] XFER_H = 4'd2;
    localparam logic [3:0] XFER_W = 4'd4;
    localparam logic [3:0] XFER_D = 4'd8;

    typedef struct packed {
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   dm_read_data;
        logic              MemtoReg;
        logic              RegWrite;
        logic [RIDX_W-1:0] rd;
        logic [3:0]        xfer_size;
        logic              load_signed;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Memory-stage to writeback-stage handoff bus.
interface mem_wb_stage_if;
    import cpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   dm_read_data;
    logic [XLEN-1:0]   alu_result;
    logic              MemtoReg;
    logic              RegWrite;
    logic [RIDX_W-1:0] rd;
    logic [3:0]        xfer_size;
    logic              load_signed;

    modport master (
        output in_valid, dm_read_data, alu_result, MemtoReg, RegWrite, rd,
               xfer_size, load_signed,
        input  in_ready
    );

    modport slave (
        input  in_valid, dm_read_data, alu_result, MemtoReg, RegWrite, rd,
               xfer_size, load_signed,
        output in_ready
    );

endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Load-width extraction with sign or zero extension to the full datapath.
module load_extend
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [3:0]      xfer_size,
    input  logic            load_signed,
    output logic [XLEN-1:0] ext
);

    // Unknown size encodings fall through to a full-width load.
    always_comb begin
        ext = data;
        case (xfer_size)
            XFER_B: ext = load_signed ? {{56{data[7]}}, data[7:0]}   : {56'd0, data[7:0]};
            XFER_H: ext = load_signed ? {{48{data[15]}}, data[15:0]} : {48'd0, data[15:0]};
            XFER_W: ext = load_signed ? {{32{data[31]}}, data[31:0]} : {32'd0, data[31:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: MEM/WB register, load extension, writeback mux,
// register-file write gating, forwarding tap and retired counter.
module mem_wb_stage #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned XZR_IDX = 31,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_wb_stage_if.slave     bus,
    input  logic              hold,
    input  logic              flush,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired
);

    cpu_pkg::mem_wb_t mw_q, mw_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] retired_q;
    logic [DATA_W-1:0] load_val;
    logic              live;
    logic              leave;

    assign bus.in_ready = !hold;

    // Next-state of the pipeline register: flush beats hold beats load.
    always_comb begin
        valid_d = valid_q;
        mw_d    = mw_q;
        if (flush) begin
            valid_d = 1'b0;
            mw_d    = '0;
        end else if (!hold) begin
            valid_d = bus.in_valid;
            if (bus.in_valid) begin
                mw_d.alu_result   = bus.alu_result;
                mw_d.dm_read_data = bus.dm_read_data;
                mw_d.MemtoReg     = bus.MemtoReg;
                mw_d.RegWrite     = bus.RegWrite;
                mw_d.rd           = bus.rd;
                mw_d.xfer_size    = bus.xfer_size;
                mw_d.load_signed  = bus.load_signed;
            end
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mw_q    <= '0;
        end else begin
            valid_q <= valid_d;
            mw_q    <= mw_d;
        end
    end

    load_extend u_load_extend (
        .data        (mw_q.dm_read_data),
        .xfer_size   (mw_q.xfer_size),
        .load_signed (mw_q.load_signed),
        .ext         (load_val)
    );

    // The entry leaves the stage on an edge with neither hold nor flush.
    assign leave = valid_q & !hold & !flush;
    assign live  = valid_q & mw_q.RegWrite & (mw_q.rd != REG_AW'(XZR_IDX));

    // Writeback mux and write/forward gating; forwarding ignores hold.
    always_comb begin
        wb_data   = mw_q.MemtoReg ? load_val : mw_q.alu_result;
        wb_rd     = mw_q.rd;
        wb_we     = live & !hold & !flush;
        fwd_valid = live;
        fwd_rd    = mw_q.rd;
        fwd_data  = wb_data;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (leave) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        wb_we, fwd_valid;
    logic [4:0]  wb_rd, fwd_rd;
    logic [63:0] wb_data, fwd_data;
    logic [31:0] retired;

    logic        wb_we2, fwd_valid2;
    logic [4:0]  wb_rd2, fwd_rd2;
    logic [63:0] wb_data2, fwd_data2;
    logic [1:0]  retired2;

    int errors = 0;
    int checks = 0;

    mem_wb_stage_if bus ();
    mem_wb_stage_if bus2 ();

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .hold      (hold),
        .flush     (flush),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .retired   (retired)
    );

    // Narrow counter instance to exercise wrap-around in a few cycles.
    mem_wb_stage #(.CNT_W(2)) dut_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2.slave),
        .hold      (1'b0),
        .flush     (1'b0),
        .wb_we     (wb_we2),
        .wb_rd     (wb_rd2),
        .wb_data   (wb_data2),
        .fwd_valid (fwd_valid2),
        .fwd_rd    (fwd_rd2),
        .fwd_data  (fwd_data2),
        .retired   (retired2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one instruction for a single edge, then drop in_valid.
    task automatic issue(input logic mtr, input logic rw, input logic [4:0] rdi,
                         input logic [63:0] alu, input logic [63:0] dm,
                         input logic [3:0] sz, input logic sgn);
        bus.MemtoReg     = mtr;
        bus.RegWrite     = rw;
        bus.rd           = rdi;
        bus.alu_result   = alu;
        bus.dm_read_data = dm;
        bus.xfer_size    = sz;
        bus.load_signed  = sgn;
        bus.in_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.MemtoReg = 1'b0; bus.RegWrite = 1'b0; bus.rd = '0;
        bus.alu_result = '0; bus.dm_read_data = '0; bus.xfer_size = '0; bus.load_signed = 1'b0;
        bus2.in_valid = 1'b0; bus2.MemtoReg = 1'b0; bus2.RegWrite = 1'b1; bus2.rd = 5'd1;
        bus2.alu_result = 64'h1; bus2.dm_read_data = '0; bus2.xfer_size = 4'd8;
        bus2.load_signed = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we", wb_we, 0);
        check_eq("rst_rd", wb_rd, 0);
        check_eq("rst_data", wb_data, 0);
        check_eq("rst_fwd_valid", fwd_valid, 0);
        check_eq("rst_fwd_rd", fwd_rd, 0);
        check_eq("rst_retired", retired, 0);
        check_eq("rst_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        issue(1'b0, 1'b1, 5'd3, 64'h80, 64'h0, 4'd8, 1'b0);
        check_eq("alu_we", wb_we, 1);
        check_eq("alu_rd", wb_rd, 3);
        check_eq("alu_data", wb_data, 64'h80);
        check_eq("alu_fwd_data", fwd_data, 64'h80);
        check_eq("alu_retired0", retired, 0);

        issue(1'b1, 1'b1, 5'd4, 64'h1000, 64'hF5, 4'd1, 1'b1);
        check_eq("lb_signed", wb_data, 64'hFFFF_FFFF_FFFF_FFF5);
        check_eq("lb_we", wb_we, 1);
        check_eq("alu_retired1", retired, 1);

        issue(1'b1, 1'b1, 5'd4, 64'h1000, 64'hF5, 4'd1, 1'b0);
        check_eq("lb_unsigned", wb_data, 64'hF5);
        check_eq("retired2", retired, 2);

        issue(1'b1, 1'b1, 5'd8, 64'h2000, 64'h1234_5678_8000_0000, 4'd4, 1'b1);
        check_eq("lw_signed", wb_data, 64'hFFFF_FFFF_8000_0000);
        check_eq("retired3", retired, 3);

        issue(1'b1, 1'b1, 5'd9, 64'h2000, 64'h0000_AAAA_0000_8001, 4'd2, 1'b1);
        check_eq("lh_signed", wb_data, 64'hFFFF_FFFF_FFFF_8001);

        issue(1'b1, 1'b1, 5'd9, 64'h2000, 64'hDEAD_BEEF_CAFE_F00D, 4'd3, 1'b1);
        check_eq("size3_full", wb_data, 64'hDEAD_BEEF_CAFE_F00D);

        issue(1'b0, 1'b1, 5'd10, 64'hFF, 64'h80, 4'd1, 1'b1);
        check_eq("alu_no_ext", wb_data, 64'hFF);
        check_eq("retired6", retired, 6);

        issue(1'b0, 1'b1, 5'd31, 64'h45, 64'h0, 4'd8, 1'b0);
        check_eq("xzr_we", wb_we, 0);
        check_eq("xzr_fwd", fwd_valid, 0);
        @(posedge clk);
        #1;
        check_eq("xzr_retired", retired, 8);

        issue(1'b0, 1'b1, 5'd5, 64'h55, 64'h0, 4'd8, 1'b0);
        hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_we", wb_we, 0);
            check_eq("hold_fwd_valid", fwd_valid, 1);
            check_eq("hold_fwd_rd", fwd_rd, 5);
            check_eq("hold_ready", bus.in_ready, 0);
            check_eq("hold_retired", retired, 8);
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        hold = 1'b0;
        #1;
        check_eq("release_we", wb_we, 1);
        check_eq("release_data", wb_data, 64'h55);
        @(posedge clk);
        #1;
        check_eq("release_once", wb_we, 0);
        check_eq("release_retired", retired, 9);

        issue(1'b0, 1'b1, 5'd6, 64'h66, 64'h0, 4'd8, 1'b0);
        hold = 1'b1;
        flush = 1'b1;
        #1;
        check_eq("flush_we", wb_we, 0);
        @(posedge clk);
        #1;
        hold = 1'b0;
        flush = 1'b0;
        #1;
        check_eq("flush_fwd", fwd_valid, 0);
        check_eq("flush_we_after", wb_we, 0);
        check_eq("flush_retired", retired, 9);
        @(posedge clk);
        #1;
        check_eq("bubble_fwd", fwd_valid, 0);
        check_eq("bubble_retired", retired, 9);

        issue(1'b0, 1'b1, 5'd7, 64'h77, 64'h0, 4'd8, 1'b0);
        hold = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midhold_fwd", fwd_valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_fwd_valid", fwd_valid, 0);
        check_eq("arst_fwd_rd", fwd_rd, 0);
        check_eq("arst_data", wb_data, 0);
        check_eq("arst_retired", retired, 0);
        hold = 1'b0;
        #1;
        check_eq("arst_we", wb_we, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_we", wb_we, 0);
        check_eq("post_rst_retired", retired, 0);

        bus2.in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check_eq("wrap_cnt", 64'(retired2), 64'((k - 1) % 4));
        end
        bus2.in_valid = 1'b0;
        check_eq("wrap_zero", 64'(retired2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
